// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ds_pkg
// Description : Shared types and constants for the Downscaler configuration
//               scheduler: downscale mode encoding and scheduler FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ds_pkg;

    typedef enum logic [2:0] {
        DS_BYPASS = 3'd0,
        DS_SUB2   = 3'd1,
        DS_SUB3   = 3'd2,
        DS_AVG2   = 3'd3,
        DS_AVG3   = 3'd4,
        DS_CROSS3 = 3'd5
    } ds_mode_e;

    // Highest legal mode code; anything above is rejected at the handshake.
    localparam logic [2:0] DS_MODE_MAX = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode <= DS_MODE_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Polarity-normalising edge detector. The input is XORed with
//               POL so that 1 always means "active", delayed by one flop,
//               and rise/fall pulses are produced combinationally in the
//               cycle the normalised level first changes.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               i_sig   - raw input level
//               o_rise  - normalised level went 0 -> 1 this cycle
//               o_fall  - normalised level went 1 -> 0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic w_level;
    logic r_level_d;

    assign w_level = i_sig ^ POL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign o_rise =  w_level & ~r_level_d;
    assign o_fall = ~w_level &  r_level_d;

endmodule
`default_nettype wire

// File: rtl/ds_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ds_cfg_scheduler
// Description : Frame-synchronous configuration scheduler. Mode/gray requests
//               are accepted over valid/ready, held in shadow registers and
//               committed to the Downscaler only on a vsync leading edge.
//               Also counts frames and active lines and flags frames whose
//               line count differs from VACT.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               i_vsync, i_de          - video timing (vsync polarity VSYNC_POL)
//               i_cfg_valid/o_cfg_ready- request handshake
//               i_cfg_mode, i_cfg_gray - requested mode / gray flag
//               i_err_clr              - clears o_frame_err
//               o_ds_mode, o_is_gray   - committed configuration
//               o_apply                - 1-cycle commit pulse
//               o_pending              - request waiting for next vsync
//               o_cfg_rej              - 1-cycle pulse for an illegal mode
//               o_frame_cnt            - frames seen since reset (wraps)
//               o_frame_err            - sticky line-count mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
module ds_cfg_scheduler
    import ds_pkg::*;
#(
    parameter int VACT      = 4,
    parameter int VSYNC_POL = 0,
    parameter int FCNT_W    = 16,
    parameter int LCNT_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vsync,
    input  logic              i_de,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [2:0]        i_cfg_mode,
    input  logic              i_cfg_gray,
    input  logic              i_err_clr,
    output logic [2:0]        o_ds_mode,
    output logic              o_is_gray,
    output logic              o_apply,
    output logic              o_pending,
    output logic              o_cfg_rej,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic              o_frame_err
);

    localparam logic [LCNT_W-1:0] c_vact     = LCNT_W'(VACT);
    localparam logic [LCNT_W-1:0] c_lcnt_max = '1;

    logic              w_vs_edge;
    logic              w_vs_fall;
    logic              w_de_rise;
    logic              w_de_fall;
    logic              w_unused_edges;

    cfg_state_e        r_state;
    logic [2:0]        r_shadow_mode;
    logic              r_shadow_gray;
    logic [LCNT_W-1:0] r_lcnt;

    sync_edge_det #(
        .POL (VSYNC_POL != 0)
    ) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_vsync),
        .o_rise (w_vs_edge),
        .o_fall (w_vs_fall)
    );

    sync_edge_det #(
        .POL (1'b0)
    ) u_de_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_de),
        .o_rise (w_de_rise),
        .o_fall (w_de_fall)
    );

    assign w_unused_edges = w_vs_fall ^ w_de_rise;

    // Request FSM. o_cfg_ready is kept registered and always equals
    // (r_state == IDLE). Only PEND reacts to the vsync edge, so a request
    // accepted in IDLE on the very edge cycle waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shadow_mode <= DS_BYPASS;
            r_shadow_gray <= 1'b0;
            o_cfg_ready   <= 1'b1;
            o_pending     <= 1'b0;
            o_apply       <= 1'b0;
            o_cfg_rej     <= 1'b0;
            o_ds_mode     <= DS_BYPASS;
            o_is_gray     <= 1'b0;
        end else begin
            o_apply   <= 1'b0;
            o_cfg_rej <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cfg_valid && o_cfg_ready) begin
                        if (!mode_is_legal(i_cfg_mode)) begin
                            o_cfg_rej <= 1'b1;
                        end else begin
                            r_shadow_mode <= i_cfg_mode;
                            r_shadow_gray <= i_cfg_gray;
                            r_state       <= PEND;
                            o_pending     <= 1'b1;
                            o_cfg_ready   <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (w_vs_edge) begin
                        o_ds_mode <= r_shadow_mode;
                        o_is_gray <= r_shadow_gray;
                        o_apply   <= 1'b1;
                        o_pending <= 1'b0;
                        r_state   <= APPLY;
                    end
                end
                APPLY: begin
                    r_state     <= IDLE;
                    o_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    o_cfg_ready <= 1'b1;
                    o_pending   <= 1'b0;
                end
            endcase
        end
    end

    // Frame/line accounting. The check runs on the pre-clear line count;
    // frame 0 after reset has no complete previous frame, so it only primes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt      <= '0;
            o_frame_cnt <= '0;
            o_frame_err <= 1'b0;
        end else begin
            if (w_vs_edge) begin
                r_lcnt      <= '0;
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end else if (w_de_fall && (r_lcnt != c_lcnt_max)) begin
                r_lcnt <= r_lcnt + 1'b1;
            end

            if (w_vs_edge && (o_frame_cnt != '0) && (r_lcnt != c_vact)) begin
                o_frame_err <= 1'b1;
            end else if (i_err_clr) begin
                o_frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ds_cfg_scheduler
// Description : Self-checking bench for ds_cfg_scheduler. Frames are built
//               from line/blank cycles; requests are placed at chosen or
//               random cycles. An event-level reference model predicts the
//               committed configuration, pending/ready windows and frame
//               accounting; commit and reject pulses are checked by a
//               separate monitor against scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ds_cfg_scheduler;

    localparam int VACT      = 4;
    localparam int VSYNC_POL = 0;
    localparam int FCNT_W    = 16;
    localparam int LCNT_W    = 12;
    localparam int c_never   = 32'h7fff_ffff;
    localparam int c_lmax    = (1 << LCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vsync = 1'b0;
    logic              de = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [2:0]        cfg_mode = 3'd0;
    logic              cfg_gray = 1'b0;
    logic              err_clr = 1'b0;
    logic              cfg_ready;
    logic [2:0]        ds_mode;
    logic              is_gray;
    logic              apply;
    logic              pending;
    logic              cfg_rej;
    logic [FCNT_W-1:0] frame_cnt;
    logic              frame_err;

    always #5 clk = ~clk;

    ds_cfg_scheduler #(
        .VACT      (VACT),
        .VSYNC_POL (VSYNC_POL),
        .FCNT_W    (FCNT_W),
        .LCNT_W    (LCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_vsync     (vsync),
        .i_de        (de),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_mode  (cfg_mode),
        .i_cfg_gray  (cfg_gray),
        .i_err_clr   (err_clr),
        .o_ds_mode   (ds_mode),
        .o_is_gray   (is_gray),
        .o_apply     (apply),
        .o_pending   (pending),
        .o_cfg_rej   (cfg_rej),
        .o_frame_cnt (frame_cnt),
        .o_frame_err (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc;
    int         m_ready_cyc;
    bit         m_pending;
    logic [2:0] m_sh_mode;
    bit         m_sh_gray;
    logic [2:0] m_mode;
    bit         m_gray;
    int         m_lines;
    int         m_frames;
    bit         m_err;
    bit         prev_vs;
    bit         prev_de;
    logic [3:0] q_apply[$];
    bit         q_rej[$];

    task automatic model_reset();
        cyc         = 0;
        m_ready_cyc = 0;
        m_pending   = 0;
        m_sh_mode   = 3'd0;
        m_sh_gray   = 0;
        m_mode      = 3'd0;
        m_gray      = 0;
        m_lines     = 0;
        m_frames    = 0;
        m_err       = 0;
        prev_vs     = 0;
        prev_de     = 0;
        q_apply.delete();
        q_rej.delete();
    endtask

    // One clock cycle: compare outputs with the model, drive inputs,
    // advance the model by this cycle's events, then clock.
    task automatic step(input bit vs, input bit de_i, input bit valid,
                        input logic [2:0] mode, input bit gray, input bit clr);
        bit ready_now;
        bit vs_edge;
        bit de_fall;
        ready_now = (cyc >= m_ready_cyc);
        chk("ready",     32'(cfg_ready), 32'(ready_now));
        chk("pending",   32'(pending),   32'(m_pending));
        chk("ds_mode",   32'(ds_mode),   32'(m_mode));
        chk("is_gray",   32'(is_gray),   32'(m_gray));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % (1 << FCNT_W)));
        chk("frame_err", 32'(frame_err), 32'(m_err));

        vsync     = vs ^ (VSYNC_POL != 0);
        de        = de_i;
        cfg_valid = valid;
        cfg_mode  = mode;
        cfg_gray  = gray;
        err_clr   = clr;

        vs_edge = vs & !prev_vs;
        de_fall = prev_de & !de_i;

        if (vs_edge) begin
            if (m_pending) begin
                q_apply.push_back({m_sh_gray, m_sh_mode});
                m_mode      = m_sh_mode;
                m_gray      = m_sh_gray;
                m_pending   = 0;
                m_ready_cyc = cyc + 2;
            end
            if (m_frames != 0 && m_lines != VACT) m_err = 1;
            else if (clr)                         m_err = 0;
            m_frames++;
            m_lines = 0;
        end else begin
            if (de_fall && m_lines < c_lmax) m_lines++;
            if (clr) m_err = 0;
        end

        if (valid && ready_now) begin
            if (mode > 3'd5) begin
                q_rej.push_back(1'b1);
            end else begin
                m_pending   = 1;
                m_sh_mode   = mode;
                m_sh_gray   = gray;
                m_ready_cyc = c_never;
            end
        end

        prev_vs = vs;
        prev_de = de_i;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Frame: 2 vsync cycles, 2 blank, nlines x (3 de + 2 blank), 2 blank.
    // Index 0 is the vsync leading-edge cycle. Up to two requests and one
    // error clear may be placed at given indices (-1 = none).
    task automatic run_frame(input int nlines,
                             input int wr_at, input logic [2:0] mode, input bit gray,
                             input int wr2_at, input logic [2:0] mode2, input bit gray2,
                             input int clr_at);
        int len;
        len = 4 + 5 * nlines + 2;
        for (int i = 0; i < len; i++) begin
            bit vs_i;
            bit de_v;
            bit v;
            logic [2:0] md;
            bit gy;
            vs_i = (i < 2);
            de_v = (i >= 4) && (i < 4 + 5 * nlines) && (((i - 4) % 5) < 3);
            v    = (i == wr_at) || (i == wr2_at);
            md   = (i == wr2_at) ? mode2 : mode;
            gy   = (i == wr2_at) ? gray2 : gray;
            step(vs_i, de_v, v, md, gy, (i == clr_at));
        end
    endtask

    task automatic run_random_frame(input int nlines, input bit allow_clr);
        int len;
        int w1;
        int w2;
        int c;
        len = 4 + 5 * nlines + 2;
        w1  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, len - 1));
        w2  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len - 1));
        c   = (allow_clr && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        run_frame(nlines, w1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  w2, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        vsync     = (VSYNC_POL != 0);
        de        = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode  = 3'd0;
        cfg_gray  = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ds_mode",   32'(ds_mode),   32'd0);
        chk("rst_is_gray",   32'(is_gray),   32'd0);
        chk("rst_ready",     32'(cfg_ready), 32'd1);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- pulse monitor ----------------
    logic [3:0] mon_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (apply) begin
                if (q_apply.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL apply_unexpected: got pulse mode=%0d expected no pulse", ds_mode);
                end else begin
                    mon_exp = q_apply.pop_front();
                    chk("apply_mode", 32'(ds_mode), 32'(mon_exp[2:0]));
                    chk("apply_gray", 32'(is_gray), 32'(mon_exp[3]));
                end
            end
            if (cfg_rej) begin
                if (q_rej.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rej_unexpected: got reject pulse expected none");
                end else begin
                    chk("rej_pulse", 32'(cfg_rej), 32'(q_rej.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // priming frame, then basic commit of mode 3 / gray 1 mid-frame
        run_frame(4, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        run_frame(4, 8, 3'd3, 1, -1, 3'd0, 0, -1);
        chk("basic_pending", 32'(pending), 32'd1);
        chk("basic_hold",    32'(ds_mode), 32'd0);
        run_frame(4, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        chk("basic_mode", 32'(ds_mode), 32'd3);
        chk("basic_gray", 32'(is_gray), 32'd1);

        // illegal modes
        run_frame(4, 8, 3'd6, 0, 20, 3'd7, 1, -1);
        chk("rej_pending", 32'(pending), 32'd0);
        chk("rej_mode",    32'(ds_mode), 32'd3);

        // backpressure: second request while pending is dropped
        run_frame(4, 8, 3'd2, 0, 12, 3'd5, 1, -1);
        chk("bp_ready", 32'(cfg_ready), 32'd0);
        run_frame(4, 2, 3'd5, 1, -1, 3'd0, 0, -1);
        chk("bp_first_mode", 32'(ds_mode), 32'd2);
        run_frame(4, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        chk("bp_second_mode", 32'(ds_mode), 32'd5);
        chk("bp_second_gray", 32'(is_gray), 32'd1);

        // request on the vsync edge cycle waits a frame
        run_frame(4, 0, 3'd4, 0, -1, 3'd0, 0, -1);
        chk("coll_hold",    32'(ds_mode), 32'd5);
        chk("coll_pending", 32'(pending), 32'd1);
        run_frame(4, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        chk("coll_mode", 32'(ds_mode), 32'd4);

        // reset while a request is pending
        run_frame(4, 5, 3'd1, 1, -1, 3'd0, 0, -1);
        do_reset();
        chk("mid_rst_pending", 32'(pending), 32'd0);
        run_frame(2, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd1);
        chk("mid_rst_err", 32'(frame_err), 32'd0);

        // ten good frames with random requests
        do_reset();
        for (int f = 0; f < 10; f++) run_random_frame(4, 0);
        chk("ten_frame_cnt", 32'(frame_cnt), 32'd10);
        chk("ten_frame_err", 32'(frame_err), 32'd0);

        // short frame flagged at the next edge, then cleared
        run_frame(3, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        run_frame(4, -1, 3'd0, 0, -1, 3'd0, 0, -1);
        chk("short_err_set", 32'(frame_err), 32'd1);
        step(0, 0, 0, 3'd0, 0, 1);
        chk("short_err_clr", 32'(frame_err), 32'd0);

        // random frames with varying line counts and clears
        for (int f = 0; f < 20; f++) run_random_frame(int'($urandom_range(3, 5)), 1);

        repeat (4) step(0, 0, 0, 3'd0, 0, 0);
        chk("apply_queue_drained", 32'(q_apply.size()), 32'd0);
        chk("rej_queue_drained",   32'(q_rej.size()),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
